// File: rtl/muldiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : EX-stage multiply/divide unit that owns the HI/LO register
//                pair. A mult/multu/div/divu start takes its operands on the
//                start edge and computes the result into a pending pair. The
//                unit then stays busy for a fixed number of cycles and commits
//                the pending pair into HI/LO on the last busy edge.
//                mthi/mtlo write HI/LO directly and never raise busy.
//
//  Ports       : clk_i    - rising-edge clock
//                reset_i  - asynchronous active-high reset, clears all state
//                start_i  - EX holds a valid muldiv-class instruction
//                op_i     - 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo,
//                           6/7 no-op
//                a_i      - rs operand (dividend / multiplicand / mthi data)
//                b_i      - rt operand (divisor / multiplier)
//                busy_o   - operation in flight (registered)
//                hi_o     - committed HI register (registered)
//                lo_o     - committed LO register (registered)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int C_CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int C_CW      = $clog2(C_CNT_MAX + 1);

    localparam logic [C_CW-1:0] C_MULT_LOAD = C_CW'(MULT_CYCLES);
    localparam logic [C_CW-1:0] C_DIV_LOAD  = C_CW'(DIV_CYCLES);
    localparam logic [C_CW-1:0] C_CNT_ONE   = C_CW'(1);

    localparam logic [2:0] C_OP_MULT  = 3'd0;
    localparam logic [2:0] C_OP_MULTU = 3'd1;
    localparam logic [2:0] C_OP_DIV   = 3'd2;
    localparam logic [2:0] C_OP_DIVU  = 3'd3;
    localparam logic [2:0] C_OP_MTHI  = 3'd4;
    localparam logic [2:0] C_OP_MTLO  = 3'd5;

    localparam logic [31:0] C_INT_MIN = 32'h8000_0000;
    localparam logic [31:0] C_NEG_ONE = 32'hFFFF_FFFF;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t            state_q;
    logic [C_CW-1:0]   cnt_q;
    logic              busy_q;
    logic [31:0]       hi_q;
    logic [31:0]       lo_q;
    logic [31:0]       pend_hi_q;
    logic [31:0]       pend_lo_q;
    logic              div0_q;     // pending op was a divide by zero: no commit

    // ------------------------------------------------------------------------
    // Result datapath (computed from the operands present on the start edge)
    // ------------------------------------------------------------------------
    logic [31:0]        pend_hi_d;
    logic [31:0]        pend_lo_d;
    logic               div0_d;
    logic [C_CW-1:0]    cnt_load_d;
    logic               is_arith_d;
    logic               commit_edge_d;
    logic               accept_d;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] divisor_safe;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quot_u;
    logic        [31:0] rem_u;
    logic               div_ovf;

    always_comb begin
        prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
        prod_u = {32'd0, a_i} * {32'd0, b_i};

        // Substitute a divisor of 1 for zero so the dividers never see /0;
        // the result is discarded anyway through div0_q.
        divisor_safe = (b_i == 32'd0) ? 32'd1 : b_i;

        // INT_MIN / -1 overflows a 32-bit signed quotient; the architected
        // answer is quotient INT_MIN, remainder 0.
        div_ovf = (a_i == C_INT_MIN) && (b_i == C_NEG_ONE);

        if (div_ovf) begin
            quot_s = $signed(C_INT_MIN);
            rem_s  = 32'sd0;
        end else begin
            quot_s = $signed(a_i) / $signed(divisor_safe);
            rem_s  = $signed(a_i) % $signed(divisor_safe);
        end

        quot_u = a_i / divisor_safe;
        rem_u  = a_i % divisor_safe;
    end

    always_comb begin
        pend_hi_d  = pend_hi_q;
        pend_lo_d  = pend_lo_q;
        div0_d     = 1'b0;
        cnt_load_d = C_MULT_LOAD;
        is_arith_d = 1'b0;

        case (op_i)
            C_OP_MULT: begin
                pend_hi_d  = prod_s[63:32];
                pend_lo_d  = prod_s[31:0];
                is_arith_d = 1'b1;
            end
            C_OP_MULTU: begin
                pend_hi_d  = prod_u[63:32];
                pend_lo_d  = prod_u[31:0];
                is_arith_d = 1'b1;
            end
            C_OP_DIV: begin
                pend_hi_d  = rem_s;
                pend_lo_d  = quot_s;
                div0_d     = (b_i == 32'd0);
                cnt_load_d = C_DIV_LOAD;
                is_arith_d = 1'b1;
            end
            C_OP_DIVU: begin
                pend_hi_d  = rem_u;
                pend_lo_d  = quot_u;
                div0_d     = (b_i == 32'd0);
                cnt_load_d = C_DIV_LOAD;
                is_arith_d = 1'b1;
            end
            default: begin
                is_arith_d = 1'b0;
            end
        endcase

        // The last busy edge both commits the old result and accepts a new
        // start, so back-to-back operations see no idle gap.
        commit_edge_d = (state_q == S_RUN) && (cnt_q == C_CNT_ONE);
        accept_d      = start_i && ((state_q == S_IDLE) || commit_edge_d);
    end

    // ------------------------------------------------------------------------
    // Control FSM and HI/LO state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            div0_q    <= 1'b0;
        end else begin
            // Step 1: advance or retire the operation in flight.
            if (state_q == S_RUN) begin
                if (cnt_q == C_CNT_ONE) begin
                    if (!div0_q) begin
                        hi_q <= pend_hi_q;
                        lo_q <= pend_lo_q;
                    end
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end else begin
                    cnt_q <= cnt_q - C_CNT_ONE;
                end
            end

            // Step 2: accept a new instruction. Later assignments win, so an
            // mthi/mtlo on the commit edge overrides the freshly committed
            // value, and a new arithmetic op keeps busy asserted.
            if (accept_d) begin
                if (is_arith_d) begin
                    pend_hi_q <= pend_hi_d;
                    pend_lo_q <= pend_lo_d;
                    div0_q    <= div0_d;
                    cnt_q     <= cnt_load_d;
                    busy_q    <= 1'b1;
                    state_q   <= S_RUN;
                end else if (op_i == C_OP_MTHI) begin
                    hi_q <= a_i;
                end else if (op_i == C_OP_MTLO) begin
                    lo_q <= a_i;
                end
            end
        end
    end

    assign busy_o = busy_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Self-checking bench for muldiv_unit. A cycle-stamped model
//                tracks when each operation completes and what HI/LO must
//                hold; a compare process checks busy/HI/LO every cycle, and
//                directed scenarios check hand-computed literal results.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op    = 3'd6;
    logic [31:0] a     = 32'd0;
    logic [31:0] b     = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_unit #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_dut (
        .clk_i   (clk),
        .reset_i (reset),
        .start_i (start),
        .op_i    (op),
        .a_i     (a),
        .b_i     (b),
        .busy_o  (busy),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    always #5 clk = ~clk;

    int n_checks   = 0;
    int n_fail     = 0;
    int proto_errs = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model: an operation started at cycle t completes at cycle
    // t+N; HI/LO change only at completion or via mthi/mtlo.
    // ------------------------------------------------------------------------
    longint      cyc       = 0;
    longint      m_done_at = 0;
    logic        m_busy    = 1'b0;
    logic        m_div0    = 1'b0;
    logic [31:0] m_hi      = 32'd0;
    logic [31:0] m_lo      = 32'd0;
    logic [31:0] m_phi     = 32'd0;
    logic [31:0] m_plo     = 32'd0;

    always @(posedge clk or posedge reset) begin
        longint      sa, sb, q, r, p;
        logic [63:0] pu;
        if (reset) begin
            m_busy = 1'b0; m_div0 = 1'b0;
            m_hi   = 32'd0; m_lo  = 32'd0;
            m_phi  = 32'd0; m_plo = 32'd0;
        end else begin
            cyc++;
            if (m_busy && cyc == m_done_at) begin
                if (!m_div0) begin
                    m_hi = m_phi;
                    m_lo = m_plo;
                end
                m_busy = 1'b0;
            end
            if (start) begin
                if (m_busy) begin
                    proto_errs++;
                    $display("Note: protocol error - start op=%0d while busy at cycle %0d, ignored", op, cyc);
                end else begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    case (op)
                        3'd0: begin
                            p = sa * sb;
                            m_phi = p[63:32]; m_plo = p[31:0];
                            m_div0 = 1'b0; m_busy = 1'b1; m_done_at = cyc + MULT_CYCLES;
                        end
                        3'd1: begin
                            pu = {32'd0, a} * {32'd0, b};
                            m_phi = pu[63:32]; m_plo = pu[31:0];
                            m_div0 = 1'b0; m_busy = 1'b1; m_done_at = cyc + MULT_CYCLES;
                        end
                        3'd2: begin
                            m_div0 = (b == 32'd0);
                            if (!m_div0) begin
                                q = sa / sb; r = sa % sb;
                                m_phi = r[31:0]; m_plo = q[31:0];
                            end
                            m_busy = 1'b1; m_done_at = cyc + DIV_CYCLES;
                        end
                        3'd3: begin
                            m_div0 = (b == 32'd0);
                            if (!m_div0) begin
                                m_phi = a % b; m_plo = a / b;
                            end
                            m_busy = 1'b1; m_done_at = cyc + DIV_CYCLES;
                        end
                        3'd4: m_hi = a;
                        3'd5: m_lo = a;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            check("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
            check("cyc_hi", hi, m_hi);
            check("cyc_lo", lo, m_lo);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        @(posedge clk); #2;
        start = 1'b1; op = o; a = av; b = bv;
        @(posedge clk); #2;
        start = 1'b0; op = 3'd6;
    endtask

    // Counts cycles with busy high, starting just after the start edge.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) n++;
            else return;
        end
        check("busy_timeout", 32'd1, 32'd0);
    endtask

    int n;

    initial begin
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        @(negedge clk); reset = 1'b0;

        // mthi / mtlo
        issue(3'd4, 32'h1234_5678, 32'd0);
        #1;
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        issue(3'd5, 32'h0BAD_F00D, 32'd0);
        #1;
        check("mtlo_lo", lo, 32'h0BAD_F00D);

        // Reset mid-RUN: busy drops at once, no late commit afterwards.
        issue(3'd0, 32'd3, 32'd4);
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("rstrun_busy", {31'd0, busy}, 32'd0);
        check("rstrun_hi", hi, 32'd0);
        check("rstrun_lo", lo, 32'd0);
        @(posedge clk); #2;
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        check("rstrun_late_busy", {31'd0, busy}, 32'd0);
        check("rstrun_late_hi", hi, 32'd0);
        check("rstrun_late_lo", lo, 32'd0);

        // Signed mult -2 * 3
        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        #1;
        check("mult_hold_lo", lo, 32'd0);
        count_busy(n);
        check("mult_cycles", n, 32'd5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        // multu 0xFFFFFFFF^2
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        count_busy(n);
        check("multu_cycles", n, 32'd5);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);

        // div -7 / 2
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        count_busy(n);
        check("div_cycles", n, 32'd10);
        check("div_hi", hi, 32'hFFFF_FFFF);
        check("div_lo", lo, 32'hFFFF_FFFD);

        // divu by zero keeps HI/LO
        issue(3'd3, 32'd7, 32'd0);
        count_busy(n);
        check("div0_cycles", n, 32'd10);
        check("div0_hi", hi, 32'hFFFF_FFFF);
        check("div0_lo", lo, 32'hFFFF_FFFD);

        // INT_MIN / -1
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        count_busy(n);
        check("ovf_hi", hi, 32'd0);
        check("ovf_lo", lo, 32'h8000_0000);

        // Back-to-back: div accepted on the edge the mult commits.
        @(posedge clk); #2;
        start = 1'b1; op = 3'd0; a = 32'd6; b = 32'd7;
        @(posedge clk); #2;             // start edge T0
        start = 1'b0; op = 3'd6;
        repeat (4) @(posedge clk);      // T0+4
        #2;
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
        @(posedge clk); #2;             // T0+5: commit + accept
        start = 1'b0; op = 3'd6;
        check("b2b_busy", {31'd0, busy}, 32'd1);
        check("b2b_mult_lo", lo, 32'd42);
        check("b2b_mult_hi", hi, 32'd0);
        count_busy(n);
        check("b2b_div_cycles", n, 32'd10);
        check("b2b_div_lo", lo, 32'd14);
        check("b2b_div_hi", hi, 32'd2);

        // mtlo during RUN is ignored.
        issue(3'd0, 32'd5, 32'd9);
        @(posedge clk); #2;
        start = 1'b1; op = 3'd5; a = 32'h0000_DEAD;
        @(posedge clk); #2;
        start = 1'b0; op = 3'd6;
        count_busy(n);
        check("ign_lo", lo, 32'd45);
        check("ign_hi", hi, 32'd0);
        check("ign_proto_errs", proto_errs, 32'd1);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
